// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: duty-word source for the 4-bit PWM stage.
// Pass-through, triangle, sawtooth or slew; DUTY_RAMP_DWELL_EN adds endpoint dwell.
module pwm_duty_ramp #(
  parameter int WIDTH       = 4,
  parameter int STEP_TICKS  = 750000,
  parameter int DWELL_STEPS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] duty,
  output logic             step
);

  localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(STEP_TICKS - 1);
  localparam logic [WIDTH-1:0] MAX      = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_TRI  = 2'b01,
    MODE_SAW  = 2'b10,
    MODE_SLEW = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  mode_e            mode_m_q, mode_m_d;
  mode_e            mode_s_q, mode_s_d;
  mode_e            mode_p_q, mode_p_d;
  logic [WIDTH-1:0] target_m_q, target_m_d;
  logic [WIDTH-1:0] target_s_q, target_s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             step_q, step_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] duty_q, duty_d;

  logic tick;
  logic mode_chg;
  logic hold;

  assign tick     = (cnt_q == CNT_LAST);
  assign mode_chg = (mode_s_q != mode_p_q);

`ifdef DUTY_RAMP_DWELL_EN
  localparam int DW = (DWELL_STEPS > 0) ? $clog2(DWELL_STEPS + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_STEPS);

  logic [DW-1:0] dwell_q, dwell_d;
  logic          at_end;

  // endpoint detection and dwell counting for triangle/sawtooth
  always_comb begin
    at_end = 1'b0;
    unique case (mode_s_q)
      MODE_TRI: at_end = (dir_q == DIR_UP) ? (duty_q == MAX)
                                           : (duty_q == '0);
      MODE_SAW: at_end = (duty_q == MAX);
      default:  at_end = 1'b0;
    endcase
    hold    = at_end && (dwell_q != DWELL_LAST);
    dwell_d = dwell_q;
    if (mode_chg) begin
      dwell_d = '0;
    end else if (tick && at_end) begin
      dwell_d = hold ? dwell_q + 1'b1 : '0;
    end
  end

  // dwell counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`else
  assign hold = 1'b0;
`endif

  // two-flop synchronizers plus the last-seen mode for change detect
  always_comb begin
    mode_m_d   = mode_e'(mode);
    mode_s_d   = mode_m_q;
    mode_p_d   = mode_s_q;
    target_m_d = target;
    target_s_d = target_m_q;
  end

  // step prescaler; a mode change restarts it and drops that step
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    step_d = tick;
    if (mode_chg) begin
      cnt_d  = '0;
      step_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
    end
  end

  // duty word and ramp direction update
  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    if (mode_chg) begin
      dir_d = DIR_UP;
    end else begin
      unique case (mode_s_q)
        MODE_PASS: begin
          duty_d = target_s_q;
        end
        MODE_TRI: begin
          if (tick) begin
            if (dir_q == DIR_UP) begin
              if (duty_q != MAX) begin
                duty_d = duty_q + 1'b1;
              end else if (!hold) begin
                dir_d  = DIR_DN;
                duty_d = MAX - 1'b1;
              end
            end else begin
              if (duty_q != '0) begin
                duty_d = duty_q - 1'b1;
              end else if (!hold) begin
                dir_d  = DIR_UP;
                duty_d = ONE;
              end
            end
          end
        end
        MODE_SAW: begin
          if (tick && !hold) begin
            duty_d = duty_q + 1'b1;
          end
        end
        MODE_SLEW: begin
          if (tick) begin
            unique case (1'b1)
              (duty_q < target_s_q): duty_d = duty_q + 1'b1;
              (duty_q > target_s_q): duty_d = duty_q - 1'b1;
              default:               duty_d = duty_q;
            endcase
          end
        end
        default: begin
          duty_d = duty_q;
        end
      endcase
    end
  end

  // state registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_m_q   <= MODE_PASS;
      mode_s_q   <= MODE_PASS;
      mode_p_q   <= MODE_PASS;
      target_m_q <= '0;
      target_s_q <= '0;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= DIR_UP;
      duty_q     <= '0;
    end else begin
      mode_m_q   <= mode_m_d;
      mode_s_q   <= mode_s_d;
      mode_p_q   <= mode_p_d;
      target_m_q <= target_m_d;
      target_s_q <= target_s_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      duty_q     <= duty_d;
    end
  end

  assign duty = duty_q;
  assign step = step_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: directed checks of pwm_duty_ramp with STEP_TICKS=4.
// Covers reset, triangle, mode restart, pass latency, sawtooth, slew.
module tb_pwm_duty_ramp;

  localparam int W  = 4;
  localparam int ST = 4;
  localparam int DS = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   mode;
  logic [W-1:0] target;
  logic [W-1:0] duty;
  logic         step;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pwm_duty_ramp #(
    .WIDTH      (W),
    .STEP_TICKS (ST),
    .DWELL_STEPS(DS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .target(target),
    .duty  (duty),
    .step  (step)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_step(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * ST + 8; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_step_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_q[$];
    int unsigned c0;
    int unsigned last;

    reset  = 1'b1;
    mode   = 2'b01;
    target = '0;
    repeat (3) @(negedge clk);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    @(negedge clk);
    chk("rst_duty2", 32'(duty), 32'd0);
    reset = 1'b0;
    c0    = cyc;

    for (int v = 1; v <= 15; v++) exp_q.push_back(v);
`ifdef DUTY_RAMP_DWELL_EN
    for (int i = 0; i < DS; i++) exp_q.push_back(15);
`endif
    for (int v = 14; v >= 0; v--) exp_q.push_back(v);
`ifdef DUTY_RAMP_DWELL_EN
    for (int i = 0; i < DS; i++) exp_q.push_back(0);
`endif
    exp_q.push_back(1);

    last = 0;
    foreach (exp_q[k]) begin
      wait_step("tri");
      chk("tri_duty", 32'(duty), 32'(exp_q[k]));
      if (k == 0) chk("tri_first_lat", cyc - c0, 32'd7);
      else        chk("tri_period", cyc - last, 32'(ST));
      last = cyc;
    end

    for (int k = 0; k < 20; k++) begin
      wait_step("tri_to10");
      if (duty === 4'd10) break;
    end
    chk("tri_at10", 32'(duty), 32'd10);

    mode = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("chg_hold_duty", 32'(duty), 32'd10);
      chk("chg_no_step", 32'(step), 32'd0);
    end
    @(negedge clk);
    chk("chg_step", 32'(step), 32'd1);
    chk("chg_duty", 32'(duty), 32'd9);

    repeat (2) @(negedge clk);
    reset  = 1'b1;
    mode   = 2'b00;
    target = 4'd5;
    @(negedge clk);
    chk("midrst_duty", 32'(duty), 32'd0);
    chk("midrst_step", 32'(step), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("pass_5", 32'(duty), 32'd5);

    target = 4'd9;
    @(negedge clk);
    chk("pass_lat1", 32'(duty), 32'd5);
    @(negedge clk);
    chk("pass_lat2", 32'(duty), 32'd5);
    @(negedge clk);
    chk("pass_lat3", 32'(duty), 32'd9);
    wait_step("pass");
    chk("pass_at_step", 32'(duty), 32'd9);
    wait_step("pass2");
    chk("pass_at_step2", 32'(duty), 32'd9);

    target = 4'd14;
    repeat (4) @(negedge clk);
    chk("saw_pre", 32'(duty), 32'd14);
    mode = 2'b10;
    repeat (3) @(negedge clk);
    chk("saw_keep", 32'(duty), 32'd14);
    wait_step("saw");
    chk("saw_15", 32'(duty), 32'd15);
`ifdef DUTY_RAMP_DWELL_EN
    for (int i = 0; i < DS; i++) begin
      wait_step("saw_dw");
      chk("saw_dwell", 32'(duty), 32'd15);
    end
`endif
    wait_step("saw");
    chk("saw_0", 32'(duty), 32'd0);
    wait_step("saw");
    chk("saw_1", 32'(duty), 32'd1);

    mode   = 2'b00;
    target = 4'd3;
    repeat (4) @(negedge clk);
    chk("slew_pre", 32'(duty), 32'd3);
    mode   = 2'b11;
    target = 4'd7;
    repeat (3) @(negedge clk);
    chk("slew_keep", 32'(duty), 32'd3);
    for (int v = 4; v <= 7; v++) begin
      wait_step("slew_up");
      chk("slew_up", 32'(duty), 32'(v));
    end
    wait_step("slew_hold");
    chk("slew_hold", 32'(duty), 32'd7);
    target = 4'd2;
    for (int v = 6; v >= 2; v--) begin
      wait_step("slew_dn");
      chk("slew_dn", 32'(duty), 32'(v));
    end
    wait_step("slew_hold2");
    chk("slew_hold2", 32'(duty), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
